// File: rtl/inst_buffer_pkg.sv
// Shared pipeline types: instruction buffer entry layout and default sizing.
package pipeline_type;

  localparam int INST_BUFFER_DEPTH = 8;
  localparam int INST_BUFFER_EXC_W = 7;

  typedef struct packed {
    logic [31:0]                  pc;
    logic [31:0]                  inst;
    logic                         is_branch;
    logic                         is_exception;
    logic [INST_BUFFER_EXC_W-1:0] exception_cause;
  } inst_buffer_entry_t;

endpackage

// File: rtl/inst_buffer_regfile.sv
// Entry storage for the instruction buffer: two write ports, two
// combinational read ports. No pointer logic lives here.
module inst_buffer_regfile #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 73
) (
  input  logic                     clk,
  input  logic                     we_1,
  input  logic [$clog2(DEPTH)-1:0] waddr_1,
  input  logic [WIDTH-1:0]         wdata_1,
  input  logic                     we_2,
  input  logic [$clog2(DEPTH)-1:0] waddr_2,
  input  logic [WIDTH-1:0]         wdata_2,
  input  logic [$clog2(DEPTH)-1:0] raddr_1,
  output logic [WIDTH-1:0]         rdata_1,
  input  logic [$clog2(DEPTH)-1:0] raddr_2,
  output logic [WIDTH-1:0]         rdata_2
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Write both ports; the controller never gives them the same address.
  always_ff @(posedge clk) begin
    if (we_1) mem[waddr_1] <= wdata_1;
    if (we_2) mem[waddr_2] <= wdata_2;
  end

  assign rdata_1 = mem[raddr_1];
  assign rdata_2 = mem[raddr_2];

endmodule

// File: rtl/inst_buffer.sv
// Two-wide instruction queue between fetch and decode. Registered writes,
// combinational reads of the two oldest entries, stall from count only.
module inst_buffer
  import pipeline_type::*;
#(
  parameter int DEPTH = INST_BUFFER_DEPTH,
  parameter int EXC_W = INST_BUFFER_EXC_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             branch_flush,
  input  logic             in_en_1,
  input  logic             in_en_2,
  input  logic [31:0]      in_pc_1,
  input  logic [31:0]      in_pc_2,
  input  logic [31:0]      in_inst_1,
  input  logic [31:0]      in_inst_2,
  input  logic             in_is_branch_1,
  input  logic             in_is_branch_2,
  input  logic             in_is_exception,
  input  logic [EXC_W-1:0] in_exception_cause,
  output logic             buffer_stall,
  output logic             out_valid_1,
  output logic             out_valid_2,
  output logic [31:0]      out_pc_1,
  output logic [31:0]      out_pc_2,
  output logic [31:0]      out_inst_1,
  output logic [31:0]      out_inst_2,
  output logic             out_is_branch_1,
  output logic             out_is_branch_2,
  output logic             out_is_exception_1,
  output logic             out_is_exception_2,
  output logic [EXC_W-1:0] out_exception_cause_1,
  output logic [EXC_W-1:0] out_exception_cause_2,
  input  logic             dec_accept_1,
  input  logic             dec_accept_2
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic [31:0]      pc;
    logic [31:0]      inst;
    logic             is_branch;
    logic             is_exception;
    logic [EXC_W-1:0] exception_cause;
  } entry_t;

  logic [AW-1:0] head_ptr;
  logic [AW-1:0] tail_ptr;
  logic [CW-1:0] count;
  logic          we_1;
  logic          we_2;
  logic [CW-1:0] pushes;
  logic [CW-1:0] pops;
  entry_t        slot_1;
  entry_t        slot_2;
  entry_t        wdata_1;
  entry_t        rd_1;
  entry_t        rd_2;

  // Fewer than two free entries: fetch must hold, regardless of decode.
  assign buffer_stall = (count > CW'(DEPTH - 2));
  assign out_valid_1  = (count != '0);
  assign out_valid_2  = (count > CW'(1));

  assign slot_1 = '{pc: in_pc_1, inst: in_inst_1, is_branch: in_is_branch_1,
                    is_exception: in_is_exception, exception_cause: in_exception_cause};
  assign slot_2 = '{pc: in_pc_2, inst: in_inst_2, is_branch: in_is_branch_2,
                    is_exception: in_is_exception, exception_cause: in_exception_cause};

  // Push/pop decode: slot 2 alone lands at tail; accept 2 needs accept 1.
  always_comb begin
    we_1    = 1'b0;
    we_2    = 1'b0;
    wdata_1 = slot_1;
    pushes  = '0;
    pops    = '0;
    if (!buffer_stall && !branch_flush) begin
      we_1    = in_en_1 | in_en_2;
      we_2    = in_en_1 & in_en_2;
      wdata_1 = in_en_1 ? slot_1 : slot_2;
      pushes  = CW'(we_1) + CW'(we_2);
    end
    pops = CW'(dec_accept_1 & out_valid_1) + CW'(dec_accept_1 & dec_accept_2 & out_valid_2);
  end

  inst_buffer_regfile #(
    .DEPTH (DEPTH),
    .WIDTH ($bits(entry_t))
  ) u_regfile (
    .clk     (clk),
    .we_1    (we_1 & rst_n),
    .waddr_1 (tail_ptr),
    .wdata_1 (wdata_1),
    .we_2    (we_2 & rst_n),
    .waddr_2 (tail_ptr + AW'(1)),
    .wdata_2 (slot_2),
    .raddr_1 (head_ptr),
    .rdata_1 (rd_1),
    .raddr_2 (head_ptr + AW'(1)),
    .rdata_2 (rd_2)
  );

  assign out_pc_1              = out_valid_1 ? rd_1.pc              : '0;
  assign out_inst_1            = out_valid_1 ? rd_1.inst            : '0;
  assign out_is_branch_1       = out_valid_1 ? rd_1.is_branch       : 1'b0;
  assign out_is_exception_1    = out_valid_1 ? rd_1.is_exception    : 1'b0;
  assign out_exception_cause_1 = out_valid_1 ? rd_1.exception_cause : '0;
  assign out_pc_2              = out_valid_2 ? rd_2.pc              : '0;
  assign out_inst_2            = out_valid_2 ? rd_2.inst            : '0;
  assign out_is_branch_2       = out_valid_2 ? rd_2.is_branch       : 1'b0;
  assign out_is_exception_2    = out_valid_2 ? rd_2.is_exception    : 1'b0;
  assign out_exception_cause_2 = out_valid_2 ? rd_2.exception_cause : '0;

  // Pointer and occupancy update; reset beats flush, flush beats push/pop.
  always_ff @(posedge clk) begin
    if (!rst_n || branch_flush) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      count    <= '0;
    end else begin
      head_ptr <= head_ptr + AW'(pops);
      tail_ptr <= tail_ptr + AW'(pushes);
      count    <= count + pushes - pops;
    end
  end

endmodule

// File: doc/inst_buffer.md
Name: inst_buffer

Overview:
- Dual-entry-wide instruction queue between branch-prediction/fetch and decode.
- Each cycle it accepts up to two fetched instructions (pc, inst, exception info, branch flag) and presents the two oldest entries to decode.
- Decouples fetch from decode stalls, provides backpressure to fetch, and is cleared on branch_flush.

Parameters:
- DEPTH, 8: number of entries; power of two, minimum 4.
- EXC_W, 7: width of exception_cause.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- branch_flush  in  1  discard all contents
- in_en_1  in  1  slot 1 of fetch packet valid
- in_en_2  in  1  slot 2 of fetch packet valid
- in_pc_1, in_pc_2  in  32 each  instruction addresses
- in_inst_1, in_inst_2  in  32 each  instruction words
- in_is_branch_1, in_is_branch_2  in  1 each  predecoded branch flags
- in_is_exception  in  1  fetch exception, applies to both slots of the packet
- in_exception_cause  in  EXC_W  cause code, applies to both slots
- buffer_stall  out  1  fetch must hold its packet
- out_valid_1, out_valid_2  out  1 each  head / head+1 entry valid
- out_pc_1, out_pc_2  out  32 each
- out_inst_1, out_inst_2  out  32 each
- out_is_branch_1, out_is_branch_2  out  1 each
- out_is_exception_1, out_is_exception_2  out  1 each
- out_exception_cause_1, out_exception_cause_2  out  EXC_W each
- dec_accept_1, dec_accept_2  in  1 each  decode consumes slot 1 / slot 2 this cycle

Behaviour:
- State: head_ptr and tail_ptr, each $clog2(DEPTH) bits, wrap modulo DEPTH. count is $clog2(DEPTH)+1 bits. Entry array is registers.
- Reset (rst_n=0 at a clk edge): head=tail=count=0. All out_valid_* = 0, buffer_stall = 0. Payload outputs are don't-care but drive 0 when invalid.
- Reset has priority over flush. A reset mid-operation drops every entry and ignores same-cycle push and pop.
- buffer_stall = (DEPTH - count < 2), computed from registered count only. It is conservative: no combinational path from dec_accept_*.
- Push: when buffer_stall=0 and not flushing, valid slots are written at tail in order: slot 1 first, then slot 2.
  - in_en_2 without in_en_1 pushes one entry (slot 2 data) at tail.
  - tail advances by the number of valid slots (0, 1 or 2).
  - When buffer_stall=1, inputs are ignored and fetch must hold them.
- Exception info is replicated into every entry pushed that cycle.
- Outputs are read combinationally from the array:
  - out_*_1 from entry[head], out_valid_1 = (count ≥ 1).
  - out_*_2 from entry[head+1 mod DEPTH], out_valid_2 = (count ≥ 2).
- Pop: pops = (dec_accept_1 & out_valid_1) + (dec_accept_1 & dec_accept_2 & out_valid_2). dec_accept_2 without dec_accept_1 is ignored, which keeps consumption in order. head advances by pops.
- Simultaneous push and pop: next count = count + pushes − pops. Pop reads pre-push contents.
- Latency: an entry pushed at edge N is visible on outputs after edge N (registered-in, combinational-out); minimum one cycle from fetch to decode.
- Empty: out_valid_*=0 and accepts are ignored.
- Full or near-full: count ≥ DEPTH−1 asserts buffer_stall. count never exceeds DEPTH.
- branch_flush=1 at an edge: head=tail=count=0, same-cycle pushes and pops discarded. Outputs are invalid from the next cycle.
- Wrap-around: a two-entry push or pop straddling index DEPTH−1 → 0 is handled by modulo pointers, with no bubble.

Decomposition:
- pipeline_type package gains inst_buffer_entry_t: pc[31:0], inst[31:0], is_branch, is_exception, exception_cause[EXC_W-1:0].
- pipeline_type package also gains the constant INST_BUFFER_DEPTH = 8.
- The top module handles pointers, count, stall and flush.
- Optional sub-module inst_buffer_regfile: 2-write/2-read register array with a write-enable per port. It holds no pointer logic.

Test Plan:
1. Reset then push pc 0x1c000000/0x1c000004 with both in_en, dec_accept=0 → next cycle out_valid_1=out_valid_2=1, out_pc_1=0x1c000000, out_pc_2=0x1c000004, count=2.
2. Fill with dec_accept=0, pushing 2 per cycle at DEPTH=8 → buffer_stall=1 once count=8 (after 4 pushes), 5th packet not written, out_pc_1 still the first pc.
3. Full buffer, dec_accept_1=1 only → count 8→7, buffer_stall stays 1. Then accept both → count 5, buffer_stall=0, next packet accepted.
4. Steady state: push 2 and accept 2 every cycle for 20 cycles → pcs emerge in strictly increasing order with no gaps through pointer wrap, count constant at 2.
5. count=5, then branch_flush=1 with a same-cycle push → count=0, out_valid_*=0 next cycle; a push on the following cycle appears at out_pc_1.
6. in_en_1=0, in_en_2=1 with in_is_exception=1, cause=0x08, on an empty buffer → one entry, out_valid_1=1, out_valid_2=0, out_pc_1=in_pc_2, out_is_exception_1=1, cause 0x08. Also: dec_accept_2 alone is ignored.
